// File: rtl/m_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : m_dmem_resp
// Brief    : Data-memory responder; one word request at a time, programmable
//            commit latency, valid/ready request and response channels.
//            Optional macro DMEM_RESP_PIPE_EN: accept on the response edge.
// Revision : 1.0
// ============================================================================
module m_dmem_resp #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_req_we,
  input  logic [31:0] w_req_adr,
  input  logic [31:0] w_req_wd,
  input  logic [3:0]  w_req_be,
  output logic        w_rsp_valid,
  input  logic        w_rsp_ready,
  output logic [31:0] w_rsp_rd,
  output logic        w_rsp_err
);

  localparam int         c_depth   = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_latency = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;

  logic                  r_we;
  logic [31:0]           r_adr;
  logic [31:0]           r_wd;
  logic [3:0]            r_be;

  logic [31:0]           r_rsp_rd;
  logic                  r_rsp_err;

  logic [31:0]           r_mem [c_depth];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_be_mask;

`ifdef DMEM_RESP_PIPE_EN
  // A new request may ride in on the same edge that retires the response.
  assign w_req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & w_rsp_ready);
`else
  assign w_req_ready = (r_state == S_IDLE);
`endif

  assign w_rsp_valid = (r_state == S_RESP);
  assign w_rsp_rd    = r_rsp_rd;
  assign w_rsp_err   = r_rsp_err;

  assign w_accept = w_req_valid & w_req_ready;
  assign w_commit = (r_state == S_WAIT) & (r_cnt == 4'd0);
  assign w_idx    = r_adr[DEPTH_LOG2+1:2];
  assign w_err    = (r_adr[1:0] != 2'b00) | ((r_adr >> (DEPTH_LOG2 + 2)) != 32'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_be_mask[8*gi +: 8] = {8{r_be[gi]}};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_latency;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // w_accept can only be true here when pipelined acceptance is built in.
        if (w_rsp_ready) begin
          if (w_accept) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_latency;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_adr     <= 32'd0;
      r_wd      <= 32'd0;
      r_be      <= 4'd0;
      r_rsp_rd  <= 32'd0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we  <= w_req_we;
        r_adr <= w_req_adr;
        r_wd  <= w_req_wd;
        r_be  <= w_req_be;
      end
      if (w_commit) begin
        if (w_err) begin
          r_rsp_rd  <= 32'd0;
          r_rsp_err <= 1'b1;
        end else if (r_we) begin
          r_rsp_rd  <= 32'd0;
          r_rsp_err <= 1'b0;
        end else begin
          r_rsp_rd  <= r_mem[w_idx];
          r_rsp_err <= 1'b0;
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain; a reset clears r_state
  // asynchronously, so an access still in WAIT can never reach its commit.
  always_ff @(posedge w_clk) begin
    if (w_commit & r_we & ~w_err) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_be_mask) | (r_wd & w_be_mask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_dmem_resp.sv
`default_nettype none
// Self-checking bench for m_dmem_resp: table-driven transactions plus
// backpressure, mid-operation reset and back-to-back throughput sequences.
module tb_m_dmem_resp;

  localparam int LAT = 2;
`ifdef DMEM_RESP_PIPE_EN
  localparam int FAST_PERIOD = 2;
`else
  localparam int FAST_PERIOD = 3;
`endif

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic        w_rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_wd;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rd;

  logic        f_valid, f_ready_o, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_rsp_rd;

  m_dmem_resp #(.DEPTH_LOG2(12), .LATENCY(LAT)) u_dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_req_valid(req_valid),
    .w_req_ready(req_ready),
    .w_req_we   (req_we),
    .w_req_adr  (req_adr),
    .w_req_wd   (req_wd),
    .w_req_be   (req_be),
    .w_rsp_valid(rsp_valid),
    .w_rsp_ready(rsp_ready),
    .w_rsp_rd   (rsp_rd),
    .w_rsp_err  (rsp_err)
  );

  m_dmem_resp #(.DEPTH_LOG2(12), .LATENCY(0)) u_fast (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_req_valid(f_valid),
    .w_req_ready(f_ready_o),
    .w_req_we   (1'b0),
    .w_req_adr  (32'h0000_0001),
    .w_req_wd   (32'd0),
    .w_req_be   (4'd0),
    .w_rsp_valid(f_rsp_valid),
    .w_rsp_ready(f_rsp_ready),
    .w_rsp_rd   (f_rsp_rd),
    .w_rsp_err  (f_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  // Issue one request from IDLE; returns response fields and the number of
  // edges from the accept edge to the first one showing rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat);
    @(negedge w_clk);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wd = wd; req_be = be;
    @(posedge w_clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_adr = 32'hFFFF_FFFF; req_wd = ~wd; req_be = ~be;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge w_clk);
      #1;
      lat++;
    end
    rd  = rsp_rd;
    err = rsp_err;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          prev;
    int          nvalid;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[15] = '{1'b1, 32'h0000_0030, 32'h0,         4'hF, 32'h0,         1'b0};
    vecs[16] = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[17] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'hA, 32'h0,         1'b0};
    vecs[19] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hAA34_CC78, 1'b0};

    w_rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = 32'd0; req_wd = 32'd0; req_be = 4'd0;
    rsp_ready = 1'b1;
    f_valid = 1'b0; f_rsp_ready = 1'b1;

    #12;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rd",    rsp_rd,             32'd0);
    check("reset rsp_err",   {31'd0, rsp_err},   32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    #1;
    check("post-reset req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      do_req(vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].be, rd, err, lat);
      check($sformatf("vec%0d latency", i), lat, LAT + 1);
      check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d idle ready", i), {31'd0, req_ready}, 32'd1);
      check($sformatf("vec%0d idle valid", i), {31'd0, rsp_valid}, 32'd0);
    end

    // Response data persists after the handshake until the next commit.
    check("rd held after handshake", rsp_rd, 32'hAA34_CC78);

    // Reset during WAIT drops the pending store to 0x30.
    @(negedge w_clk);
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h30; req_wd = 32'h55; req_be = 4'hF;
    @(posedge w_clk);
    #1;
    req_valid = 1'b0;
    @(posedge w_clk);
    #1;
    check("midop still waiting", {31'd0, rsp_valid}, 32'd0);
    w_rst_n = 1'b0;
    #1;
    check("midop reset rd",    rsp_rd,             32'd0);
    check("midop reset err",   {31'd0, rsp_err},   32'd0);
    check("midop reset valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    #1;
    check("midop release ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat);
    check("midop load 0x30 rd",  rd,           32'd0);
    check("midop load 0x30 err", {31'd0, err}, 32'd0);

    // Backpressure with a second request held pending.
    @(negedge w_clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h10; req_wd = 32'd0; req_be = 4'h0;
    @(posedge w_clk);
    #1;
    req_adr = 32'h20;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge w_clk);
      #1;
      lat++;
    end
    check("bp first latency", lat, LAT + 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d valid", k),     {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d rd", k),        rsp_rd,             32'hDEAD_BEEF);
      check($sformatf("bp%0d err", k),       {31'd0, rsp_err},   32'd0);
      check($sformatf("bp%0d req_ready", k), {31'd0, req_ready}, 32'd0);
      @(posedge w_clk);
      #1;
    end
    @(negedge w_clk);
    rsp_ready = 1'b1;
    @(posedge w_clk);
    #1;
    rsp_ready = 1'b0;
    check("bp after pulse valid", {31'd0, rsp_valid}, 32'd0);
    check("bp after pulse rd",    rsp_rd,             32'hDEAD_BEEF);
`ifdef DMEM_RESP_PIPE_EN
    check("bp accepted on handshake", {31'd0, req_ready}, 32'd0);
`else
    check("bp idle ready", {31'd0, req_ready}, 32'd1);
    @(posedge w_clk);
    #1;
    check("bp accepted next edge", {31'd0, req_ready}, 32'd0);
`endif
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge w_clk);
      #1;
      lat++;
    end
    check("bp second latency", lat, LAT + 1);
    check("bp second rd",      rsp_rd,           32'h11BB_33DD);
    check("bp second err",     {31'd0, rsp_err}, 32'd0);
    @(negedge w_clk);
    rsp_ready = 1'b1;
    @(posedge w_clk);
    #1;
    check("bp final idle", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back throughput on the zero-latency instance.
    @(negedge w_clk);
    f_valid = 1'b1;
    prev = -1;
    nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge w_clk);
      #1;
      if (f_rsp_valid === 1'b1) begin
        nvalid++;
        check($sformatf("fast err c%0d", c), {31'd0, f_rsp_err}, 32'd1);
        if (prev >= 0) check($sformatf("fast gap c%0d", c), c - prev, FAST_PERIOD);
        prev = c;
      end
    end
    check("fast response count", nvalid, 30 / FAST_PERIOD);
    f_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
